// File: rtl/wt_wbuf_pkg.sv
// rtl/wt_wbuf_pkg.sv - shared types for the write-through store buffer
package wt_wbuf_pkg;

    localparam int unsigned DfltDepth  = 8;
    localparam int unsigned DfltAddrW  = 64;
    localparam int unsigned DfltDataW  = 64;
    localparam int unsigned DfltTidW   = 4;
    localparam int unsigned WbufIdxW   = $clog2(DfltDepth);

    typedef enum logic [1:0] {
        FREE = 2'd0,
        OPEN = 2'd1,
        SENT = 2'd2
    } wbuf_state_e;

    typedef logic [WbufIdxW-1:0] wbuf_idx_t;

    // One aligned 64-bit word; the entry types fix the default geometry,
    // so the top-level parameters must keep these widths.
    typedef struct packed {
        wbuf_state_e              state;
        logic [DfltAddrW-4:0]     word_addr;
        logic [DfltDataW-1:0]     data;
        logic [DfltDataW/8-1:0]   be;
    } wbuf_entry_t;

endpackage

// File: rtl/wt_dcache_wbuf_coalescer_lzc.sv
// rtl/wt_dcache_wbuf_coalescer_lzc.sv - lowest-set-bit index finder
module wt_dcache_wbuf_coalescer_lzc #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] in_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             empty_o
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        cnt_o = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                cnt_o = CNT_W'(i);
            end
        end
        empty_o = ~|in_i;
    end

endmodule

// File: rtl/wt_dcache_wbuf_coalescer.sv
// rtl/wt_dcache_wbuf_coalescer.sv - write-through store buffer with same-word merging
module wt_dcache_wbuf_coalescer #(
    parameter int unsigned WBUF_DEPTH    = wt_wbuf_pkg::DfltDepth,
    parameter int unsigned ADDR_WIDTH    = wt_wbuf_pkg::DfltAddrW,
    parameter int unsigned DATA_WIDTH    = wt_wbuf_pkg::DfltDataW,
    parameter int unsigned MEM_TID_WIDTH = wt_wbuf_pkg::DfltTidW
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     st_valid_i,
    output logic                     st_ready_o,
    input  logic [ADDR_WIDTH-1:0]    st_addr_i,
    input  logic [DATA_WIDTH-1:0]    st_data_i,
    input  logic [DATA_WIDTH/8-1:0]  st_be_i,
    input  logic [ADDR_WIDTH-1:0]    ld_chk_addr_i,
    output logic                     ld_chk_hit_o,
    input  logic                     flush_i,
    output logic                     empty_o,
    output logic                     mem_req_valid_o,
    input  logic                     mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0]    mem_req_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_req_data_o,
    output logic [DATA_WIDTH/8-1:0]  mem_req_be_o,
    output logic [MEM_TID_WIDTH-1:0] mem_req_tid_o,
    input  logic                     mem_rsp_valid_i,
    input  logic [MEM_TID_WIDTH-1:0] mem_rsp_tid_i
);
    import wt_wbuf_pkg::*;

    localparam int unsigned BeW   = DATA_WIDTH / 8;
    localparam int unsigned WordW = ADDR_WIDTH - 3;

    wbuf_entry_t entry_q [WBUF_DEPTH];
    wbuf_entry_t entry_d [WBUF_DEPTH];

    logic [WordW-1:0]      st_word;
    logic [WordW-1:0]      ld_word;
    logic [WBUF_DEPTH-1:0] free_vec;
    logic [WBUF_DEPTH-1:0] elig_vec;
    logic [WBUF_DEPTH-1:0] merge_vec;
    wbuf_idx_t             alloc_idx;
    wbuf_idx_t             iss_idx;
    wbuf_idx_t             merge_idx;
    logic                  no_free;
    logic                  no_elig;
    logic                  merge_hit;
    logic                  issue_hs;
    logic                  st_accept;
    logic                  unused_low_bits;

    assign st_word         = st_addr_i[ADDR_WIDTH-1:3];
    assign ld_word         = ld_chk_addr_i[ADDR_WIDTH-1:3];
    assign unused_low_bits = ^{st_addr_i[2:0], ld_chk_addr_i[2:0]};

    // Classify entries: free slots, and OPEN words that may issue without
    // overtaking an earlier write to the same word still awaiting its ack.
    always_comb begin
        for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
            free_vec[i] = (entry_q[i].state == FREE);
            elig_vec[i] = (entry_q[i].state == OPEN);
            for (int j = 0; j < int'(WBUF_DEPTH); j++) begin
                if (entry_q[j].state == SENT && entry_q[j].word_addr == entry_q[i].word_addr) begin
                    elig_vec[i] = 1'b0;
                end
            end
        end
    end

    wt_dcache_wbuf_coalescer_lzc #(.WIDTH(WBUF_DEPTH)) i_lzc_free (
        .in_i    (free_vec),
        .cnt_o   (alloc_idx),
        .empty_o (no_free)
    );

    wt_dcache_wbuf_coalescer_lzc #(.WIDTH(WBUF_DEPTH)) i_lzc_issue (
        .in_i    (elig_vec),
        .cnt_o   (iss_idx),
        .empty_o (no_elig)
    );

    assign mem_req_valid_o = ~no_elig;
    assign issue_hs        = mem_req_valid_o & mem_req_ready_i;

    // Merge target: an OPEN entry for the store's word that is not leaving this cycle.
    always_comb begin
        merge_idx = '0;
        for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
            merge_vec[i] = (entry_q[i].state == OPEN) && (entry_q[i].word_addr == st_word) &&
                           !(issue_hs && iss_idx == wbuf_idx_t'(i)) && !flush_i;
        end
        for (int i = int'(WBUF_DEPTH) - 1; i >= 0; i--) begin
            if (merge_vec[i]) begin
                merge_idx = wbuf_idx_t'(i);
            end
        end
        merge_hit = |merge_vec;
    end

    assign st_ready_o = merge_hit | ~no_free;
    assign st_accept  = st_valid_i & st_ready_o;

    // Memory request payload, forced to zero while nothing is eligible.
    always_comb begin
        mem_req_addr_o = '0;
        mem_req_data_o = '0;
        mem_req_be_o   = '0;
        mem_req_tid_o  = '0;
        if (mem_req_valid_o) begin
            mem_req_addr_o = {entry_q[iss_idx].word_addr, 3'b000};
            mem_req_data_o = entry_q[iss_idx].data;
            mem_req_be_o   = entry_q[iss_idx].be;
            mem_req_tid_o  = MEM_TID_WIDTH'(iss_idx);
        end
    end

    // Load hazard and drain status over all occupied entries.
    always_comb begin
        ld_chk_hit_o = 1'b0;
        empty_o      = 1'b1;
        for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
            if (entry_q[i].state != FREE) begin
                empty_o = 1'b0;
                if (entry_q[i].word_addr == ld_word) begin
                    ld_chk_hit_o = 1'b1;
                end
            end
        end
    end

    // Entry next state: response frees, handshake sends, store merges or allocates.
    always_comb begin
        for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
            entry_d[i] = entry_q[i];
            // Responses to entries that are not SENT carry no meaning and are dropped.
            if (mem_rsp_valid_i && mem_rsp_tid_i == MEM_TID_WIDTH'(i) && entry_q[i].state == SENT) begin
                entry_d[i] = '0;
            end
            if (issue_hs && iss_idx == wbuf_idx_t'(i)) begin
                entry_d[i].state = SENT;
            end
            if (st_accept && merge_hit && merge_idx == wbuf_idx_t'(i)) begin
                for (int b = 0; b < int'(BeW); b++) begin
                    if (st_be_i[b]) begin
                        entry_d[i].data[8*b +: 8] = st_data_i[8*b +: 8];
                    end
                end
                entry_d[i].be = entry_q[i].be | st_be_i;
            end
            if (st_accept && !merge_hit && alloc_idx == wbuf_idx_t'(i)) begin
                entry_d[i].state     = OPEN;
                entry_d[i].word_addr = st_word;
                entry_d[i].data      = st_data_i;
                entry_d[i].be        = st_be_i;
            end
        end
    end

    // Entry storage; reset discards everything including in-flight writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(WBUF_DEPTH); i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            entry_q <= entry_d;
        end
    end

endmodule

// File: tb/tb_wt_dcache_wbuf_coalescer.sv
// tb/tb_wt_dcache_wbuf_coalescer.sv - self-checking bench for the store buffer coalescer
module tb_wt_dcache_wbuf_coalescer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic [7:0]  st_be;
    logic [63:0] ld_addr;
    logic        ld_hit;
    logic        flush;
    logic        empty;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [63:0] req_data;
    logic [7:0]  req_be;
    logic [3:0]  req_tid;
    logic        rsp_valid;
    logic [3:0]  rsp_tid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wt_dcache_wbuf_coalescer dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .st_valid_i      (st_valid),
        .st_ready_o      (st_ready),
        .st_addr_i       (st_addr),
        .st_data_i       (st_data),
        .st_be_i         (st_be),
        .ld_chk_addr_i   (ld_addr),
        .ld_chk_hit_o    (ld_hit),
        .flush_i         (flush),
        .empty_o         (empty),
        .mem_req_valid_o (req_valid),
        .mem_req_ready_i (req_ready),
        .mem_req_addr_o  (req_addr),
        .mem_req_data_o  (req_data),
        .mem_req_be_o    (req_be),
        .mem_req_tid_o   (req_tid),
        .mem_rsp_valid_i (rsp_valid),
        .mem_rsp_tid_i   (rsp_tid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_store(input logic [63:0] a, input logic [7:0] be, input logic [63:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_be    = be;
        st_data  = d;
    endtask

    // Accept every request and acknowledge it a cycle later until the buffer is empty.
    task automatic drain(output bit ok, output int nreq);
        int q[$];
        ok   = 1'b0;
        nreq = 0;
        for (int c = 0; c < 200; c++) begin
            st_valid  = 1'b0;
            req_ready = 1'b1;
            if (q.size() > 0) begin
                rsp_valid = 1'b1;
                rsp_tid   = 4'(q.pop_front());
            end else begin
                rsp_valid = 1'b0;
            end
            #1;
            if (empty && !rsp_valid && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            if (req_valid) begin
                q.push_back(int'(req_tid));
                nreq++;
            end
            @(posedge clk);
            #1;
        end
        rsp_valid = 1'b0;
        req_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
        ld_addr = '0; flush = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_tid = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({st_ready, empty, ld_hit, req_valid} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_flags: rdy/empty/hit/vld got %b want 1100", {st_ready, empty, ld_hit, req_valid});
        end
        checks++;
        if ({req_addr, req_data, req_be, req_tid} !== '0) begin
            errors++;
            $display("FAIL reset_payload: addr %h data %h be %h tid %h want all zero", req_addr, req_data, req_be, req_tid);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_store();
        bit ok; int n;
        req_ready = 1'b1;
        put_store(64'h1000, 8'h0F, 64'h11223344);
        #1;
        checks++;
        if (req_valid !== 1'b0 || st_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_same_cycle: vld %b rdy %b want 0 1", req_valid, st_ready);
        end
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if ({req_valid, req_addr, req_be, req_tid, req_data} !== {1'b1, 64'h1000, 8'h0F, 4'd0, 64'h11223344}) begin
            errors++;
            $display("FAIL single_req: vld %b addr %h be %h tid %h data %h want 1 1000 0f 0 11223344",
                     req_valid, req_addr, req_be, req_tid, req_data);
        end
        tick();
        checks++;
        if (req_valid !== 1'b0 || empty !== 1'b0) begin
            errors++;
            $display("FAIL single_sent: vld %b empty %b want 0 0", req_valid, empty);
        end
        rsp_valid = 1'b1; rsp_tid = 4'd0;
        tick();
        rsp_valid = 1'b0;
        #1;
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL single_empty: got %b want 1", empty);
        end
        req_ready = 1'b0;
        drain(ok, n);
    endtask

    task automatic test_merge();
        bit ok; int n;
        req_ready = 1'b0;
        put_store(64'h2000, 8'h01, 64'hAA);
        tick();
        put_store(64'h2004, 8'hF0, 64'h11223344_00000000);
        #1;
        checks++;
        if (st_ready !== 1'b1) begin
            errors++;
            $display("FAIL merge_ready: got %b want 1", st_ready);
        end
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if ({req_valid, req_addr, req_be, req_tid, req_data} !== {1'b1, 64'h2000, 8'hF1, 4'd0, 64'h11223344_000000AA}) begin
            errors++;
            $display("FAIL merge_req: vld %b addr %h be %h tid %h data %h want 1 2000 f1 0 11223344000000aa",
                     req_valid, req_addr, req_be, req_tid, req_data);
        end
        drain(ok, n);
        checks++;
        if (!ok || n != 1) begin
            errors++;
            $display("FAIL merge_single_req: ok %0d requests %0d want 1 1", ok, n);
        end
    endtask

    task automatic test_full();
        bit ok; int n;
        req_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            put_store(64'h5000 + 64'(i * 8), 8'hFF, 64'(i));
            #1;
            checks++;
            if (st_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_accept_%0d: ready %b want 1", i, st_ready);
            end
            tick();
        end
        put_store(64'h5040, 8'hFF, 64'h99);
        #1;
        checks++;
        if (st_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ninth_blocked: ready %b want 0", st_ready);
        end
        tick();
        req_ready = 1'b1;
        #1;
        checks++;
        if (req_valid !== 1'b1 || req_tid !== 4'd0 || st_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_issue0: vld %b tid %h rdy %b want 1 0 0", req_valid, req_tid, st_ready);
        end
        tick();
        req_ready = 1'b0;
        rsp_valid = 1'b1; rsp_tid = 4'd0;
        #1;
        checks++;
        if (st_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_rsp_same_cycle: ready %b want 0", st_ready);
        end
        tick();
        rsp_valid = 1'b0;
        #1;
        checks++;
        if (st_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_ninth_after_free: ready %b want 1", st_ready);
        end
        tick();
        st_valid = 1'b0;
        drain(ok, n);
        checks++;
        if (!ok || n != 8) begin
            errors++;
            $display("FAIL full_drain: ok %0d requests %0d want 1 8", ok, n);
        end
    endtask

    task automatic test_waw_and_hazard();
        bit ok; int n;
        req_ready = 1'b1;
        put_store(64'h3000, 8'hFF, 64'h1);
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if (req_valid !== 1'b1 || req_tid !== 4'd0) begin
            errors++;
            $display("FAIL waw_first_issue: vld %b tid %h want 1 0", req_valid, req_tid);
        end
        tick();
        ld_addr = 64'h3004;
        put_store(64'h3000, 8'hFF, 64'h2);
        #1;
        checks++;
        if (ld_hit !== 1'b1 || st_ready !== 1'b1) begin
            errors++;
            $display("FAIL waw_hit_sent: hit %b rdy %b want 1 1", ld_hit, st_ready);
        end
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if (req_valid !== 1'b0) begin
            errors++;
            $display("FAIL waw_blocked: vld %b want 0", req_valid);
        end
        tick();
        rsp_valid = 1'b1; rsp_tid = 4'd0;
        #1;
        checks++;
        if (req_valid !== 1'b0 || ld_hit !== 1'b1) begin
            errors++;
            $display("FAIL waw_blocked_rsp_cycle: vld %b hit %b want 0 1", req_valid, ld_hit);
        end
        tick();
        rsp_valid = 1'b0;
        #1;
        checks++;
        if ({req_valid, req_tid, req_addr, req_data} !== {1'b1, 4'd1, 64'h3000, 64'h2}) begin
            errors++;
            $display("FAIL waw_second_issue: vld %b tid %h addr %h data %h want 1 1 3000 2",
                     req_valid, req_tid, req_addr, req_data);
        end
        tick();
        rsp_valid = 1'b1; rsp_tid = 4'd1;
        #1;
        checks++;
        if (ld_hit !== 1'b1) begin
            errors++;
            $display("FAIL waw_hit_second_sent: hit %b want 1", ld_hit);
        end
        tick();
        rsp_valid = 1'b0;
        #1;
        checks++;
        if (ld_hit !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL waw_hit_cleared: hit %b empty %b want 0 1", ld_hit, empty);
        end
        req_ready = 1'b0;
        ld_addr   = '0;
        drain(ok, n);
    endtask

    task automatic test_flush();
        bit ok; int n;
        req_ready = 1'b0;
        put_store(64'h6000, 8'h01, 64'h11);
        tick();
        flush = 1'b1;
        put_store(64'h6000, 8'h02, 64'h2200);
        #1;
        checks++;
        if (st_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_alloc_ready: ready %b want 1", st_ready);
        end
        tick();
        st_valid = 1'b0;
        #1;
        checks++;
        if (req_valid !== 1'b1 || req_tid !== 4'd0 || req_be !== 8'h01) begin
            errors++;
            $display("FAIL flush_no_merge: vld %b tid %h be %h want 1 0 01", req_valid, req_tid, req_be);
        end
        drain(ok, n);
        checks++;
        if (!ok || n != 2 || empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_drain: ok %0d requests %0d empty %b want 1 2 1", ok, n, empty);
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_midflight();
        req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put_store(64'h7000 + 64'(i * 8), 8'hFF, 64'hC0 + 64'(i));
            tick();
        end
        st_valid  = 1'b0;
        req_ready = 1'b1;
        repeat (3) tick();
        req_ready = 1'b0;
        ld_addr   = 64'h7008;
        #1;
        checks++;
        if (ld_hit !== 1'b1 || empty !== 1'b0 || req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_pre: hit %b empty %b vld %b want 1 0 0", ld_hit, empty, req_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({st_ready, empty, ld_hit, req_valid, req_addr, req_data, req_be, req_tid} !==
            {1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 8'h0, 4'h0}) begin
            errors++;
            $display("FAIL rstmid_outputs: rdy %b empty %b hit %b vld %b addr %h data %h be %h tid %h want 1 1 0 0 and zero payload",
                     st_ready, empty, ld_hit, req_valid, req_addr, req_data, req_be, req_tid);
        end
        tick();
        rst_n     = 1'b1;
        rsp_valid = 1'b1;
        rsp_tid   = 4'd1;
        tick();
        rsp_valid = 1'b0;
        #1;
        checks++;
        if ({st_ready, empty, ld_hit, req_valid} !== 4'b1100) begin
            errors++;
            $display("FAIL rstmid_late_rsp: rdy/empty/hit/vld got %b want 1100", {st_ready, empty, ld_hit, req_valid});
        end
        ld_addr = '0;
    endtask

    // Random traffic over six words against a memory image and per-word coverage counters.
    task automatic test_random();
        logic [63:0] ref_img [6];
        logic [63:0] mem_img [6];
        logic [63:0] mask;
        int          acc_cnt [6];
        int          acked   [6];
        int          tid_word  [16];
        int          tid_cover [16];
        bit          tid_busy  [16];
        int          outq[$];
        int          w, lw, iw, t, k, rt;
        bit          draining, exp_hit, legal, done;
        for (int i = 0; i < 6; i++) begin
            ref_img[i] = '0; mem_img[i] = '0; acc_cnt[i] = 0; acked[i] = 0;
        end
        for (int i = 0; i < 16; i++) begin
            tid_busy[i] = 1'b0; tid_word[i] = 0; tid_cover[i] = 0;
        end
        done = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            draining = (cyc >= 2000);
            w = int'($urandom_range(0, 5));
            st_valid  = !draining && ($urandom_range(0, 2) != 0);
            st_addr   = 64'h4000 + 64'(w * 8) + 64'($urandom_range(0, 7));
            st_be     = 8'($urandom_range(1, 255));
            st_data   = {$urandom, $urandom};
            req_ready = draining || ($urandom_range(0, 1) == 1);
            ld_addr   = 64'h4000 + 64'($urandom_range(0, 6) * 8) + 64'($urandom_range(0, 7));
            rsp_valid = 1'b0;
            rt        = 0;
            if (outq.size() > 0 && (draining || $urandom_range(0, 2) == 0)) begin
                k         = int'($urandom_range(0, outq.size() - 1));
                rt        = outq[k];
                outq.delete(k);
                rsp_valid = 1'b1;
                rsp_tid   = 4'(rt);
            end
            #1;
            if (draining && empty && !rsp_valid && outq.size() == 0) begin
                done = 1'b1;
                break;
            end
            lw      = int'((ld_addr - 64'h4000) >> 3);
            exp_hit = (lw < 6) && (acked[lw] < acc_cnt[lw]);
            checks++;
            if (ld_hit !== exp_hit) begin
                errors++;
                $display("FAIL rand_ld_hit cyc %0d addr %h: got %b want %b", cyc, ld_addr, ld_hit, exp_hit);
            end
            if (req_valid && req_ready) begin
                t     = int'(req_tid);
                iw    = int'((req_addr - 64'h4000) >> 3);
                legal = (req_addr[2:0] == 3'b000) && (req_addr >= 64'h4000) && (iw < 6) && (t < 8) && !tid_busy[t];
                for (int j = 0; j < 16; j++) begin
                    if (tid_busy[j] && tid_word[j] == iw) legal = 1'b0;
                end
                checks++;
                if (!legal) begin
                    errors++;
                    $display("FAIL rand_issue_legal cyc %0d: addr %h tid %0d not a legal new write", cyc, req_addr, t);
                end else begin
                    mask = '0;
                    for (int b = 0; b < 8; b++) if (req_be[b]) mask[8*b +: 8] = 8'hFF;
                    mem_img[iw]  = (mem_img[iw] & ~mask) | (req_data & mask);
                    tid_busy[t]  = 1'b1;
                    tid_word[t]  = iw;
                    tid_cover[t] = acc_cnt[iw];
                    outq.push_back(t);
                end
            end
            if (st_valid && st_ready) begin
                mask = '0;
                for (int b = 0; b < 8; b++) if (st_be[b]) mask[8*b +: 8] = 8'hFF;
                ref_img[w] = (ref_img[w] & ~mask) | (st_data & mask);
                acc_cnt[w]++;
            end
            if (rsp_valid) begin
                acked[tid_word[rt]] = tid_cover[rt];
                tid_busy[rt]        = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        st_valid  = 1'b0;
        rsp_valid = 1'b0;
        req_ready = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL rand_drain_timeout: empty %b outstanding %0d", empty, outq.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mem_img[i] !== ref_img[i]) begin
                errors++;
                $display("FAIL rand_image word %h: memory %h want %h", 64'h4000 + 64'(i * 8), mem_img[i], ref_img[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_merge();
        test_full();
        test_waw_and_hazard();
        test_flush();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
